axi4_lite_slave_regs: RTL and testbench
=======================================

// Module: axi4_lite_slave_regs
// PURPOSE
//  AXI4-Lite slave with four 32-bit read/write registers. Sits directly downstream of the
//  SoC AXI4-Lite master and terminates its AW/W/B/AR/R channels.
//  Register contents are exported as ports to drive a peripheral.
//  A one-cycle write strobe notifies the peripheral of each committed write.
// PARAMETERS
//  ADDR_W  4   AWADDR/ARADDR width; word index = addr[3:2], addr[1:0] ignored
//  DATA_W  32  WDATA/RDATA/register width
// PORTS
//  ACLK       in   1       clock, all logic on rising edge
//  ARESETn    in   1       synchronous active-low reset
//  AWADDR     in   ADDR_W  write address
//  AWVALID    in   1       write address valid
//  AWREADY    out  1       write address ready
//  WDATA      in   DATA_W  write data
//  WVALID     in   1       write data valid
//  WREADY     out  1       write data ready
//  BRESP      out  2       write response, always 2'b00 (OKAY)
//  BVALID     out  1       write response valid
//  BREADY     in   1       write response ready
//  ARADDR     in   ADDR_W  read address
//  ARVALID    in   1       read address valid
//  ARREADY    out  1       read address ready
//  RDATA      out  DATA_W  read data
//  RVALID     out  1       read data valid
//  RREADY     in   1       read data ready
//  RRESP      out  2       read response, always 2'b00 (OKAY)
//  slv_reg0..slv_reg3  out  DATA_W  register contents
//  wr_strobe  out  1       1-cycle pulse on register commit
//  wr_index   out  2       index of committed register, valid with wr_strobe
// BEHAVIOUR
//  Reset (ARESETn=0 at an edge)
//   - All outputs, registers and internal flops go to 0, including AWREADY, WREADY and ARREADY.
//   - The edge after reset release sets AWREADY=WREADY=ARREADY=1.
//   - Reset mid-transaction abandons it: no commit, no BVALID/RVALID afterwards.
//  Write path: AW, W and B states tracked independently
//   - AW handshake (AWVALID&AWREADY) at edge N: latch AWADDR[3:2]; AWREADY=0 from N+1.
//   - W handshake, same rules: latch WDATA; WREADY=0 from N+1.
//   - AW and W may complete in either order or at the same edge.
//   - Commit edge C = the first edge at which both AW and W are held (this includes the edge of the later handshake):
//     - slv_reg[idx] <= data
//     - wr_strobe=1 and wr_index=idx for cycle C+1 only
//     - BVALID=1 from C+1
//   - BVALID holds until the BREADY handshake at edge M.
//   - From M+1: BVALID=0, AWREADY=WREADY=1.
//   - One outstanding write maximum.
//   - Best-case write latency: AW/W handshake at N -> BVALID at N+1.
//  Read path
//   - AR handshake at edge N: RDATA <= slv_reg[ARADDR[3:2]]; RVALID=1 and ARREADY=0 from N+1.
//   - RDATA is stable while RVALID=1.
//   - R handshake at edge M: from M+1 RVALID=0, ARREADY=1 (RDATA keeps its last value).
//  Read and write paths are fully independent.
//   - An AR handshake on the commit edge C of the same register returns the pre-write value.
//  BRESP and RRESP are constant 2'b00; no error responses exist.
// TESTING
//  1. Reset, then AW 0x4 + W 0xDEADBEEF in the same cycle, BREADY=1 ->
//     BVALID 1 cycle later, slv_reg1=0xDEADBEEF, wr_strobe pulse with wr_index=1.
//  2. W 0x12345678 three cycles before AW 0xC ->
//     WREADY drops after the W handshake; commit slv_reg3 only after AW; exactly one BVALID.
//  3. BREADY held 0 for 5 cycles after the commit ->
//     BVALID stays 1; AWREADY/WREADY stay 0; new AWVALID not accepted until the B handshake.
//  4. Read 0x4 after test 1 with RREADY delayed 3 cycles ->
//     RDATA=0xDEADBEEF stable, RVALID held, RRESP=00; ARREADY=1 the cycle after the R handshake.
//  5. AR 0x0 on the same edge as the commit of 0xA5A5A5A5 to 0x0 ->
//     RDATA=old value 0; a following read returns 0xA5A5A5A5.
//  6. Assert ARESETn=0 while BVALID=1 ->
//     all regs and outputs 0; after release no stale BVALID; ready signals return one cycle later.

Source files
------------

// File: rtl/axi4_lite_slave_regs.sv
//==============================================================================
// Module   : axi4_lite_slave_regs
// Brief    : AXI4-Lite slave terminating AW/W/B/AR/R with four exported 32-bit
//            registers and a one-cycle commit strobe.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module axi4_lite_slave_regs #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [1:0]        RRESP,
  output logic [DATA_W-1:0] slv_reg0,
  output logic [DATA_W-1:0] slv_reg1,
  output logic [DATA_W-1:0] slv_reg2,
  output logic [DATA_W-1:0] slv_reg3,
  output logic              wr_strobe,
  output logic [1:0]        wr_index
);

  localparam logic [1:0] c_resp_okay = 2'b00;

  // Write-path state
  logic              awready_q, awready_d;
  logic              wready_q,  wready_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q,  w_held_d;
  logic [1:0]        aw_idx_q,  aw_idx_d;
  logic [DATA_W-1:0] w_data_q,  w_data_d;
  logic              bvalid_q,  bvalid_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [1:0]        wr_index_q,  wr_index_d;
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];

  // Read-path state
  logic              arready_q, arready_d;
  logic              rvalid_q,  rvalid_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_ar_hs;
  logic              w_commit;
  logic [1:0]        w_commit_idx;
  logic [DATA_W-1:0] w_commit_data;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

  always_comb begin
    w_aw_hs       = AWVALID & awready_q;
    w_w_hs        = WVALID & wready_q;
    // A handshake on this edge counts as "held" so AW/W arriving together commit at once.
    w_commit      = (aw_held_q | w_aw_hs) & (w_held_q | w_w_hs);
    w_commit_idx  = aw_held_q ? aw_idx_q : AWADDR[3:2];
    w_commit_data = w_held_q ? w_data_q : WDATA;

    aw_idx_d    = aw_idx_q;
    w_data_d    = w_data_q;
    aw_held_d   = aw_held_q | w_aw_hs;
    w_held_d    = w_held_q | w_w_hs;
    bvalid_d    = bvalid_q;
    wr_strobe_d = w_commit;
    wr_index_d  = wr_index_q;
    regs_d      = regs_q;

    if (w_aw_hs) begin
      aw_idx_d = AWADDR[3:2];
    end
    if (w_w_hs) begin
      w_data_d = WDATA;
    end

    if (w_commit) begin
      regs_d[w_commit_idx] = w_commit_data;
      wr_index_d           = w_commit_idx;
      aw_held_d            = 1'b0;
      w_held_d             = 1'b0;
      bvalid_d             = 1'b1;
    end else if (bvalid_q && BREADY) begin
      bvalid_d = 1'b0;
    end

    // Channels reopen only once nothing is held and the response has been taken.
    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
  end

  always_comb begin
    w_ar_hs  = ARVALID & arready_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    // Reads sample the registered contents, so a same-edge commit is not visible yet.
    if (w_ar_hs) begin
      rdata_d  = regs_q[ARADDR[3:2]];
      rvalid_d = 1'b1;
    end else if (rvalid_q && RREADY) begin
      rvalid_d = 1'b0;
    end
    arready_d = ~rvalid_d;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      aw_idx_q    <= '0;
      w_data_q    <= '0;
      bvalid_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      aw_idx_q    <= aw_idx_d;
      w_data_q    <= w_data_d;
      bvalid_q    <= bvalid_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = c_resp_okay;
  assign ARREADY   = arready_q;
  assign RVALID    = rvalid_q;
  assign RDATA     = rdata_q;
  assign RRESP     = c_resp_okay;
  assign slv_reg0  = regs_q[0];
  assign slv_reg1  = regs_q[1];
  assign slv_reg2  = regs_q[2];
  assign slv_reg3  = regs_q[3];
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_slave_regs.sv
//==============================================================================
// Module   : tb_axi4_lite_slave_regs
// Brief    : Directed plus randomized bench for axi4_lite_slave_regs against a
//            register-array reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_axi4_lite_slave_regs;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic [1:0]  RRESP;
  logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
  logic        wr_strobe;
  logic [1:0]  wr_index;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_reg [4];

  axi4_lite_slave_regs #(.ADDR_W(4), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP),
    .slv_reg0(slv_reg0), .slv_reg1(slv_reg1), .slv_reg2(slv_reg2), .slv_reg3(slv_reg3),
    .wr_strobe(wr_strobe), .wr_index(wr_index)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  function automatic logic [31:0] reg_port(input int i);
    case (i)
      0:       return slv_reg0;
      1:       return slv_reg1;
      2:       return slv_reg2;
      default: return slv_reg3;
    endcase
  endfunction

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_reg%0d", tag, i), reg_port(i), exp_reg[i]);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input int aw_dly,
                           input int w_dly, input int b_dly, input bit poke_aw);
    bit aw_done = 0;
    bit w_done  = 0;
    bit hs_aw, hs_w;
    int cyc = 0;
    logic [1:0] idx;
    idx = addr[3:2];
    while (!(aw_done && w_done) && cyc < 40) begin
      AWADDR  = addr;
      WDATA   = data;
      AWVALID = !aw_done && cyc >= aw_dly;
      WVALID  = !w_done && cyc >= w_dly;
      hs_aw   = AWVALID && AWREADY;
      hs_w    = WVALID && WREADY;
      step();
      cyc++;
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done  = 1;
      if (aw_done != w_done) begin
        chk("pending_bvalid", BVALID, 1'b0);
        if (w_done) chk("wready_after_w", WREADY, 1'b0);
        else        chk("awready_after_aw", AWREADY, 1'b0);
        chk("pending_reg_unchanged", reg_port(idx), exp_reg[idx]);
      end
    end
    AWVALID = 0;
    WVALID  = 0;
    if (!(aw_done && w_done)) begin
      timeout("write_handshake");
      return;
    end
    exp_reg[idx] = data;
    chk("commit_bvalid", BVALID, 1'b1);
    chk("commit_bresp", BRESP, 2'b00);
    chk("commit_strobe", wr_strobe, 1'b1);
    chk("commit_index", wr_index, idx);
    chk("commit_awready", AWREADY, 1'b0);
    chk("commit_wready", WREADY, 1'b0);
    chk_regs("commit");
    BREADY = 0;
    for (int i = 0; i < b_dly; i++) begin
      if (poke_aw) begin
        AWVALID = 1;
        AWADDR  = ~addr;
      end
      step();
      chk("bwait_bvalid", BVALID, 1'b1);
      chk("bwait_awready", AWREADY, 1'b0);
      chk("bwait_wready", WREADY, 1'b0);
      chk("bwait_strobe", wr_strobe, 1'b0);
    end
    BREADY = 1;
    step();
    BREADY  = 0;
    AWVALID = 0;
    chk("bdone_bvalid", BVALID, 1'b0);
    chk("bdone_awready", AWREADY, 1'b1);
    chk("bdone_wready", WREADY, 1'b1);
    chk("bdone_strobe", wr_strobe, 1'b0);
    chk_regs("bdone");
  endtask

  task automatic axi_read(input logic [3:0] addr, input int r_dly, input logic [31:0] exp);
    bit done = 0;
    bit hs;
    int cyc = 0;
    ARADDR  = addr;
    ARVALID = 1;
    while (!done && cyc < 20) begin
      hs = ARREADY;
      step();
      cyc++;
      done = hs;
    end
    ARVALID = 0;
    if (!done) begin
      timeout("read_handshake");
      return;
    end
    chk("rd_rvalid", RVALID, 1'b1);
    chk("rd_arready", ARREADY, 1'b0);
    chk("rd_rdata", RDATA, exp);
    chk("rd_rresp", RRESP, 2'b00);
    RREADY = 0;
    for (int i = 0; i < r_dly; i++) begin
      step();
      chk("rwait_rvalid", RVALID, 1'b1);
      chk("rwait_rdata", RDATA, exp);
    end
    RREADY = 1;
    step();
    RREADY = 0;
    chk("rdone_rvalid", RVALID, 1'b0);
    chk("rdone_arready", ARREADY, 1'b1);
    chk("rdone_rdata_kept", RDATA, exp);
  endtask

  initial begin
    logic [31:0] old_val;
    logic [31:0] rnd;
    logic [3:0]  raddr;

    ARESETn = 0;
    AWADDR = 0; AWVALID = 0; WDATA = 0; WVALID = 0; BREADY = 0;
    ARADDR = 0; ARVALID = 0; RREADY = 0;
    for (int i = 0; i < 4; i++) exp_reg[i] = 32'h0;

    // Reset state and release
    step();
    step();
    chk("rst_awready", AWREADY, 1'b0);
    chk("rst_wready", WREADY, 1'b0);
    chk("rst_arready", ARREADY, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_rvalid", RVALID, 1'b0);
    chk("rst_strobe", wr_strobe, 1'b0);
    chk_regs("rst");
    ARESETn = 1;
    step();
    chk("rel_awready", AWREADY, 1'b1);
    chk("rel_wready", WREADY, 1'b1);
    chk("rel_arready", ARREADY, 1'b1);

    // Same-cycle AW/W, immediate BREADY
    axi_write(4'h4, 32'hDEADBEEF, 0, 0, 0, 0);
    // Read back with delayed RREADY
    axi_read(4'h4, 3, exp_reg[1]);
    // W three cycles ahead of AW
    axi_write(4'hC, 32'h12345678, 3, 0, 0, 0);
    // BREADY held low with a competing AWVALID
    axi_write(4'h8, 32'hCAFEF00D, 0, 1, 5, 1);
    axi_read(4'h8, 0, exp_reg[2]);

    // AR on the same edge as a commit to the same register
    old_val = exp_reg[0];
    chk("same_edge_arready", ARREADY, 1'b1);
    AWADDR = 4'h0; WDATA = 32'hA5A5A5A5; ARADDR = 4'h0;
    AWVALID = 1; WVALID = 1; ARVALID = 1;
    step();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    exp_reg[0] = 32'hA5A5A5A5;
    chk("same_edge_rvalid", RVALID, 1'b1);
    chk("same_edge_rdata_old", RDATA, old_val);
    chk("same_edge_bvalid", BVALID, 1'b1);
    chk("same_edge_reg0", slv_reg0, exp_reg[0]);
    BREADY = 1; RREADY = 1;
    step();
    BREADY = 0; RREADY = 0;
    chk("same_edge_bdone", BVALID, 1'b0);
    chk("same_edge_rdone", RVALID, 1'b0);
    axi_read(4'h0, 1, exp_reg[0]);

    // Reset while a write response and a read response are outstanding
    AWADDR = 4'h8; WDATA = $urandom; AWVALID = 1; WVALID = 1;
    ARADDR = 4'h4; ARVALID = 1;
    step();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    chk("pre_rst_bvalid", BVALID, 1'b1);
    chk("pre_rst_rvalid", RVALID, 1'b1);
    ARESETn = 0;
    step();
    for (int i = 0; i < 4; i++) exp_reg[i] = 32'h0;
    chk("mid_rst_bvalid", BVALID, 1'b0);
    chk("mid_rst_rvalid", RVALID, 1'b0);
    chk("mid_rst_rdata", RDATA, 32'h0);
    chk("mid_rst_awready", AWREADY, 1'b0);
    chk("mid_rst_arready", ARREADY, 1'b0);
    chk("mid_rst_strobe", wr_strobe, 1'b0);
    chk("mid_rst_index", wr_index, 2'b00);
    chk_regs("mid_rst");
    ARESETn = 1;
    step();
    chk("post_rst_awready", AWREADY, 1'b1);
    chk("post_rst_wready", WREADY, 1'b1);
    chk("post_rst_arready", ARREADY, 1'b1);
    step();
    step();
    chk("post_rst_no_stale_b", BVALID, 1'b0);
    chk("post_rst_no_stale_r", RVALID, 1'b0);

    // Randomized traffic against the register-array model
    for (int n = 0; n < 60; n++) begin
      raddr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        rnd = $urandom;
        axi_write(raddr, rnd, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end else begin
        axi_read(raddr, $urandom_range(0, 3), exp_reg[raddr[3:2]]);
      end
    end
    chk_regs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
